// File: rtl/sram_like_arbiter.sv
// Two-master, one-slave sram-like arbiter: data side has priority, bounded by a
// streak limit so a waiting instruction fetch is never starved. One transaction in flight.
module sram_like_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_W        = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        addr_ok,
    input  logic        data_ok
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    state_t              state;
    logic                owner;   // 0 = inst, 1 = data
    logic [STREAK_W-1:0] streak;

    logic grant_data;
    logic sel;
    logic handshake;
    logic done;

    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        grant_data = data_req && !(inst_req && streak == STREAK_MAX);
        sel        = (state == IDLE) ? grant_data : owner;

        if (state == IDLE) req = resetn && (inst_req || data_req);
        else               req = resetn && (state == ADDR);

        // Outputs read as zero while reset is asserted, even if a master is requesting.
        wr    = resetn && (sel ? data_wr : inst_wr);
        size  = resetn ? (sel ? data_size  : inst_size)  : 2'b00;
        addr  = resetn ? (sel ? data_addr  : inst_addr)  : 32'h0;
        wdata = resetn ? (sel ? data_wdata : inst_wdata) : 32'h0;

        handshake = req && addr_ok;
        // A data_ok outside DATA only counts when it coincides with the address handshake.
        done      = resetn && data_ok && (state == DATA || handshake);

        inst_addr_ok = handshake && !sel;
        data_addr_ok = handshake &&  sel;
        inst_data_ok = done && !sel;
        data_data_ok = done &&  sel;

        inst_rdata = rdata;
        data_rdata = rdata;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            owner  <= 1'b0;
            streak <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    owner <= sel;
                    if (!addr_ok)     state <= ADDR;
                    else if (data_ok) state <= IDLE;
                    else              state <= DATA;
                end
                ADDR: if (addr_ok) state <= data_ok ? IDLE : DATA;
                DATA: if (data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (handshake) begin
                if (sel && inst_req)
                    streak <= (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
                else
                    streak <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: stimulus pushes expected handshakes into a
// scoreboard queue, a negedge monitor pops and compares each one the DUT presents.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        req, wr, addr_ok, data_ok;
    logic [31:0] addr, wdata, rdata;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        is_data_evt;  // 0 = addr_ok event, 1 = data_ok event
        logic        side;         // 0 = inst, 1 = data
        logic [34:0] val;          // {wr,size,addr} or {3'b0,rdata}
    } exp_t;

    exp_t sb[$];

    sram_like_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_compare(input logic is_data_evt, input logic side, input logic [34:0] val);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_evt: got evt=%0d side=%0d val=%0h expected=none at %0t",
                     is_data_evt, side, val, $time);
        end else begin
            e = sb.pop_front();
            check(is_data_evt ? "data_ok_side" : "addr_ok_side", {63'b0, side}, {63'b0, e.side});
            check(is_data_evt ? "rdata" : "slave_fields", {29'b0, val}, {29'b0, e.val});
            check("evt_kind", {63'b0, is_data_evt}, {63'b0, e.is_data_evt});
        end
    endtask

    // Monitor: addr_ok events are consumed before data_ok events in the same cycle.
    always @(negedge clk) begin
        if (resetn) begin
            if (inst_addr_ok && data_addr_ok) check("addr_ok_both", 64'd1, 64'd0);
            else if (inst_addr_ok || data_addr_ok) sb_compare(1'b0, data_addr_ok, {wr, size, addr});
            if (inst_data_ok && data_data_ok) check("data_ok_both", 64'd1, 64'd0);
            else if (inst_data_ok || data_data_ok)
                sb_compare(1'b1, data_data_ok, {3'b0, data_data_ok ? data_rdata : inst_rdata});
        end
    end

    task automatic exp_addr(input logic side, input logic w, input logic [1:0] sz, input logic [31:0] a);
        sb.push_back('{is_data_evt: 1'b0, side: side, val: {w, sz, a}});
    endtask

    task automatic exp_data(input logic side, input logic [31:0] d);
        sb.push_back('{is_data_evt: 1'b1, side: side, val: {3'b0, d}});
    endtask

    // Inputs change 1 time unit after the rising edge; direct checks run 3 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic slave(input logic a_ok, input logic d_ok, input logic [31:0] rd);
        addr_ok = a_ok;
        data_ok = d_ok;
        rdata   = rd;
    endtask

    initial begin
        resetn     = 1'b0;
        inst_req   = 1'b1;  inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr  = 32'hBFC0_0000; inst_wdata = 32'h0;
        data_req   = 1'b0;  data_wr = 1'b0; data_size = 2'd2;
        data_addr  = 32'h8000_0000; data_wdata = 32'h0;
        slave(1'b0, 1'b0, 32'hDEAD_BEEF);

        // Reset state: outputs low despite a pending request, rdata passes through.
        #2;
        check("rst_req", {63'b0, req}, 64'd0);
        check("rst_addr", {32'b0, addr}, 64'd0);
        check("rst_inst_addr_ok", {63'b0, inst_addr_ok}, 64'd0);
        check("rst_inst_rdata", {32'b0, inst_rdata}, 64'hDEAD_BEEF);
        check("rst_data_rdata", {32'b0, data_rdata}, 64'hDEAD_BEEF);
        check("rst_streak", {61'b0, dut.streak}, 64'd0);
        inst_req = 1'b0;
        step(); step();
        resetn = 1'b1;
        step();

        // Inst read alone: addr_ok in cycle 0, data_ok in cycle 2.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        slave(1'b1, 1'b0, 32'h0);
        exp_addr(1'b0, 1'b0, 2'd2, 32'hBFC0_0000);
        step();
        inst_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        settle();
        check("data_state_req", {63'b0, req}, 64'd0);
        step();
        slave(1'b0, 1'b1, 32'h2408_0001);
        exp_data(1'b0, 32'h2408_0001);
        step();
        slave(1'b0, 1'b0, 32'h0);

        // Simultaneous requests: data wins, inst follows after data_data_ok.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_addr = 32'h8000_0010; data_wr = 1'b1; data_size = 2'd2;
        data_wdata = 32'hCAFE_0001;
        settle();
        check("simul_addr", {32'b0, addr}, 64'h8000_0010);
        check("simul_wdata", {32'b0, wdata}, 64'hCAFE_0001);
        check("simul_wr", {63'b0, wr}, 64'd1);
        slave(1'b1, 1'b0, 32'h0);
        exp_addr(1'b1, 1'b1, 2'd2, 32'h8000_0010);
        step();
        data_req = 1'b0; data_wr = 1'b0;
        slave(1'b0, 1'b1, 32'h0);
        exp_data(1'b1, 32'h0);
        step();
        slave(1'b1, 1'b1, 32'h1111_2222);
        exp_addr(1'b0, 1'b0, 2'd2, 32'hBFC0_0004);
        exp_data(1'b0, 32'h1111_2222);
        step();
        inst_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        step();

        // Grant lock: inst owns the port through three cycles of addr_ok=0.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        settle();
        check("lock_c0_addr", {32'b0, addr}, 64'hBFC0_0008);
        step();
        data_req = 1'b1; data_addr = 32'h8000_0020;
        settle();
        check("lock_c1_addr", {32'b0, addr}, 64'hBFC0_0008);
        check("lock_c1_req", {63'b0, req}, 64'd1);
        step();
        settle();
        check("lock_c2_addr", {32'b0, addr}, 64'hBFC0_0008);
        slave(1'b1, 1'b0, 32'h0);
        exp_addr(1'b0, 1'b0, 2'd2, 32'hBFC0_0008);
        step();
        inst_req = 1'b0;
        slave(1'b0, 1'b1, 32'hAAAA_5555);
        exp_data(1'b0, 32'hAAAA_5555);
        step();
        slave(1'b1, 1'b0, 32'h0);
        exp_addr(1'b1, 1'b0, 2'd2, 32'h8000_0020);
        step();
        data_req = 1'b0;
        slave(1'b0, 1'b1, 32'h1234_5678);
        exp_data(1'b1, 32'h1234_5678);
        step();
        slave(1'b0, 1'b0, 32'h0);

        // Starvation guard: both masters always requesting -> D,D,D,D,I.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        data_req = 1'b1; data_addr = 32'h8000_0100;
        for (int k = 0; k < 5; k++) begin
            slave(1'b1, 1'b0, 32'h0);
            if (k < 4) exp_addr(1'b1, 1'b0, 2'd2, 32'h8000_0100);
            else       exp_addr(1'b0, 1'b0, 2'd2, 32'hBFC0_0100);
            step();
            slave(1'b0, 1'b1, 32'h5000_0000 + 32'(k));
            exp_data(k < 4, 32'h5000_0000 + 32'(k));
            step();
        end
        check("streak_after_inst", {61'b0, dut.streak}, 64'd0);
        inst_req = 1'b0; data_req = 1'b0;
        slave(1'b0, 1'b0, 32'h0);
        step();

        // Coincident addr_ok/data_ok on a data write, then an inst read the very next cycle.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h8000_0200;
        slave(1'b1, 1'b1, 32'h0);
        exp_addr(1'b1, 1'b1, 2'd1, 32'h8000_0200);
        exp_data(1'b1, 32'h0);
        step();
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
        slave(1'b1, 1'b0, 32'h0);
        settle();
        check("coinc_next_req", {63'b0, req}, 64'd1);
        exp_addr(1'b0, 1'b0, 2'd2, 32'hBFC0_0200);
        step();
        inst_req = 1'b0;
        slave(1'b0, 1'b1, 32'h0BAD_F00D);
        exp_data(1'b0, 32'h0BAD_F00D);
        step();

        // Async reset while in DATA: abort, and a later data_ok is not routed.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
        slave(1'b1, 1'b0, 32'h0);
        exp_addr(1'b0, 1'b0, 2'd2, 32'hBFC0_0300);
        step();
        slave(1'b0, 1'b0, 32'h0);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_req", {63'b0, req}, 64'd0);
        check("arst_state_idle", {62'b0, dut.state}, 64'd0);
        data_ok = 1'b1;
        #1;
        check("arst_inst_data_ok", {63'b0, inst_data_ok}, 64'd0);
        step();
        resetn   = 1'b1;
        inst_req = 1'b0;
        settle();
        check("stray_inst_data_ok", {63'b0, inst_data_ok}, 64'd0);
        check("stray_data_data_ok", {63'b0, data_data_ok}, 64'd0);
        step();
        slave(1'b0, 1'b0, 32'h0);
        step(); step();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Two-master, one-slave arbiter on the sram-like protocol.
- It shares a single sram-like port (towards the AXI bridge) between the instruction-side and data-side sram-like converters.
- At most one transaction is in flight. Data side has priority. A bounded-streak rule prevents instruction starvation.
- Sequences address hold, address handshake and data return, and routes addr_ok/data_ok back to the owning master only.

Parameters:
- MAX_DATA_STREAK, 4: consecutive data grants allowed while inst_req is pending; the next grant is then forced to inst.
- STREAK_W, 3: width of the streak counter. Must hold MAX_DATA_STREAK.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction master request
- inst_wr  in  1  instruction master write flag
- inst_size  in  2  instruction access size
- inst_addr  in  32  instruction address
- inst_wdata  in  32  instruction write data
- inst_rdata  out  32  read data to instruction master
- inst_addr_ok  out  1  address accepted, instruction master
- inst_data_ok  out  1  data returned, instruction master
- data_req  in  1  data master request
- data_wr  in  1  data master write flag
- data_size  in  2  data access size
- data_addr  in  32  data address
- data_wdata  in  32  data write data
- data_rdata  out  32  read data to data master
- data_addr_ok  out  1  address accepted, data master
- data_data_ok  out  1  data returned, data master
- req  out  1  shared slave request
- wr  out  1  shared write flag
- size  out  2  shared size
- addr  out  32  shared address
- wdata  out  32  shared write data
- rdata  in  32  slave read data
- addr_ok  in  1  slave address accepted
- data_ok  in  1  slave data returned

Behaviour:
- FSM states:
  - IDLE: no owner.
  - ADDR: owner locked, req asserted, waiting for addr_ok.
  - DATA: waiting for data_ok.
- Registered state: state, owner (0=inst, 1=data), streak.
- Reset (resetn low, async): state=IDLE, owner=0, streak=0. All outputs low except rdata pass-through.
- Grant selection, in IDLE, combinational:
  - data_req and not (inst_req and streak==MAX_DATA_STREAK) → data.
  - Otherwise inst_req → inst.
  - Neither → no request; req=0.
- Slave-side forwarding:
  - In IDLE, req/wr/size/addr/wdata come from the selected master in the same cycle (0-cycle latency).
  - In ADDR, they come from the locked owner. The owner is fixed until addr_ok even if the other master raises req.
  - In DATA, req=0 and the other fields hold the owner's values.
- addr_ok routing: goes only to the current owner (or to the IDLE selection) when req=1. The non-owner's addr_ok is always 0.
- Transitions:
  - IDLE, req=1, addr_ok=0 → ADDR; latch owner.
  - IDLE or ADDR, addr_ok=1, data_ok=0 → DATA; latch owner.
  - IDLE or ADDR, addr_ok=1 and data_ok=1 in the same cycle → treated as complete. data_ok is routed to that owner and the FSM goes to IDLE.
  - DATA, data_ok=1 → IDLE.
  - data_ok is only honoured in DATA, or coincident with addr_ok. A stray data_ok in IDLE or ADDR without addr_ok is ignored and not routed.
- data_ok routing and read data:
  - inst_data_ok = data_ok & owner==inst; data_data_ok likewise for data.
  - inst_rdata and data_rdata both equal rdata, combinationally. Masters sample on their own data_ok.
- Streak counter, updated at each address handshake:
  - Data granted while inst_req=1: streak+1, saturating at MAX_DATA_STREAK.
  - Inst granted, or inst_req=0: streak=0.
- Back-to-back: the cycle after completion is IDLE, so a new grant and request can issue. Throughput is at most one transaction per 2 cycles with a slave that responds in a single cycle.
- Reset mid-transaction aborts immediately: state=IDLE, no data_ok routed.

Test Plan:
- Inst read alone:
  - Stimulus: inst_req=1, addr=0xBFC00000; slave gives addr_ok in cycle 0 and data_ok with rdata=0x24080001 at cycle 2.
  - Required: inst_addr_ok in cycle 0, inst_data_ok=1 with inst_rdata=0x24080001 at cycle 2; data_addr_ok/data_data_ok stay 0.
- Simultaneous requests:
  - Stimulus: inst_req=1 and data_req=1, data_addr=0x80000010, data_wr=1, data_size=2.
  - Required: slave sees addr=0x80000010, wr=1, size=2; only data_addr_ok=1; inst is granted after data_data_ok.
- Grant lock:
  - Stimulus: inst holds req with addr_ok=0 for 3 cycles; data_req rises in cycle 1.
  - Required: addr stays at inst_addr until addr_ok; data waits.
- Starvation guard:
  - Stimulus: data_req and inst_req held high for 5 transactions, MAX_DATA_STREAK=4.
  - Required: grants are D,D,D,D,I; streak=0 after the I grant.
- Coincident addr_ok and data_ok:
  - Stimulus: data write where the slave raises addr_ok=1 and data_ok=1 in the same cycle.
  - Required: data_addr_ok=1 and data_data_ok=1 in that cycle; next cycle IDLE accepts a new inst req.
- Async reset in DATA:
  - Stimulus: drop resetn between addr_ok and data_ok.
  - Required: req=0 and state IDLE immediately; a later data_ok produces no *_data_ok.
